ofdm_symbol_framer: RTL and testbench

Cuts a continuous complex baseband sample stream into FFT-sized OFDM symbol blocks for `block_fft`. On a start pulse from the packet detector, it drops each cyclic prefix and forwards exactly `FFT_LEN` samples per symbol with `tlast` on the final sample, for a programmed number of symbols. It is the AXIS producer feeding `block_fft`'s sample port in the CSI extraction chain.

---
 rtl/csi_pkg.sv | 13 +
 rtl/axis_out_reg.sv | 49 ++++
 rtl/ofdm_symbol_framer.sv | 110 +++++++++++
 tb/tb_ofdm_symbol_framer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/csi_pkg.sv
// Shared types and defaults for the CSI extraction chain.
package csi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    EMIT = 2'd2
  } framer_state_t;

  localparam int FFT_LEN_DEFAULT = 64;
  localparam int CP_LEN_DEFAULT  = 16;

endpackage

// File: rtl/axis_out_reg.sv
// One-entry AXIS output register for complex samples plus tlast.
// Accepts a new beat whenever it is empty or its current beat is being taken.
module axis_out_reg #(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic signed [W-1:0] load_re,
  input  logic signed [W-1:0] load_im,
  input  logic                load_last,
  input  logic                ready,
  output logic                can_load,
  output logic                valid,
  output logic signed [W-1:0] re,
  output logic signed [W-1:0] im,
  output logic                last
);

  logic                valid_reg;
  logic signed [W-1:0] re_reg;
  logic signed [W-1:0] im_reg;
  logic                last_reg;

  assign can_load = !valid_reg || ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      re_reg    <= '0;
      im_reg    <= '0;
      last_reg  <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      re_reg    <= load_re;
      im_reg    <= load_im;
      last_reg  <= load_last;
    end else if (ready) begin
      // Data is left in place once taken; only valid drops.
      valid_reg <= 1'b0;
    end
  end

  assign valid = valid_reg;
  assign re    = re_reg;
  assign im    = im_reg;
  assign last  = last_reg;

endmodule

// File: rtl/ofdm_symbol_framer.sv
// Strips the cyclic prefix from each OFDM symbol after a packet start and
// forwards FFT_LEN-sample blocks with tlast, for a programmed symbol count.
module ofdm_symbol_framer
  import csi_pkg::*;
#(
  parameter int FFT_LEN = FFT_LEN_DEFAULT,
  parameter int CP_LEN  = CP_LEN_DEFAULT
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  input  logic [7:0]         num_symbols_in,
  input  logic               in_axis_tvalid,
  input  logic signed [15:0] in_re_axis_tdata,
  input  logic signed [15:0] in_im_axis_tdata,
  output logic               in_axis_tready,
  output logic               out_axis_tvalid,
  output logic               out_axis_tlast,
  output logic signed [15:0] out_re_axis_tdata,
  output logic signed [15:0] out_im_axis_tdata,
  input  logic               out_axis_tready,
  output logic               busy
);

  localparam int CW = $clog2(FFT_LEN);
  localparam logic [CW-1:0] CP_END  = CW'(CP_LEN - 1);
  localparam logic [CW-1:0] FFT_END = CW'(FFT_LEN - 1);

  framer_state_t state_reg;
  logic [CW-1:0] cnt_reg;
  logic [7:0]    sym_left_reg;
  logic          busy_reg;

  logic can_load;
  logic accept;
  logic load;

  assign in_axis_tready = !rst_in && ((state_reg != EMIT) || can_load);
  assign accept         = in_axis_tvalid && in_axis_tready;
  assign load           = accept && (state_reg == EMIT);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      sym_left_reg <= '0;
      busy_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // A sample accepted in the start cycle is still discarded.
          if (start_in && (num_symbols_in != 8'd0)) begin
            sym_left_reg <= num_symbols_in;
            cnt_reg      <= '0;
            state_reg    <= SKIP;
            busy_reg     <= 1'b1;
          end
        end
        SKIP: begin
          if (accept) begin
            if (cnt_reg == CP_END) begin
              cnt_reg   <= '0;
              state_reg <= EMIT;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        EMIT: begin
          if (accept) begin
            if (cnt_reg == FFT_END) begin
              cnt_reg      <= '0;
              sym_left_reg <= sym_left_reg - 8'd1;
              if (sym_left_reg == 8'd1) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
              end else begin
                state_reg <= SKIP;
              end
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_reg;

  axis_out_reg #(.W(16)) u_out (
    .clk       (clk_in),
    .rst       (rst_in),
    .load      (load),
    .load_re   (in_re_axis_tdata),
    .load_im   (in_im_axis_tdata),
    .load_last (cnt_reg == FFT_END),
    .ready     (out_axis_tready),
    .can_load  (can_load),
    .valid     (out_axis_tvalid),
    .re        (out_re_axis_tdata),
    .im        (out_im_axis_tdata),
    .last      (out_axis_tlast)
  );

endmodule

// File: tb/tb_ofdm_symbol_framer.sv
// Directed bench for ofdm_symbol_framer: ramp input, expected blocks computed
// from the ramp index (block b, position j carries sample b*80 + 16 + j).
module tb_ofdm_symbol_framer;

  logic               clk_in = 1'b0;
  logic               rst_in = 1'b1;
  logic               start_in = 1'b0;
  logic [7:0]         num_symbols_in = 8'd0;
  logic               in_axis_tvalid = 1'b0;
  logic signed [15:0] in_re_axis_tdata = '0;
  logic signed [15:0] in_im_axis_tdata = '0;
  logic               in_axis_tready;
  logic               out_axis_tvalid;
  logic               out_axis_tlast;
  logic signed [15:0] out_re_axis_tdata;
  logic signed [15:0] out_im_axis_tdata;
  logic               out_axis_tready = 1'b1;
  logic               busy;

  ofdm_symbol_framer dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .start_in          (start_in),
    .num_symbols_in    (num_symbols_in),
    .in_axis_tvalid    (in_axis_tvalid),
    .in_re_axis_tdata  (in_re_axis_tdata),
    .in_im_axis_tdata  (in_im_axis_tdata),
    .in_axis_tready    (in_axis_tready),
    .out_axis_tvalid   (out_axis_tvalid),
    .out_axis_tlast    (out_axis_tlast),
    .out_re_axis_tdata (out_re_axis_tdata),
    .out_im_axis_tdata (out_im_axis_tdata),
    .out_axis_tready   (out_axis_tready),
    .busy              (busy)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic        last;
  } beat_t;

  beat_t q[$];
  int    errors = 0;
  int    checks = 0;
  int    k = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output collector plus hold-while-stalled check.
  logic        stalled_prev = 1'b0;
  logic [15:0] held_re, held_im;
  logic        held_last;
  always @(posedge clk_in) begin
    if (rst_in) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev) begin
        chk("hold_re", {16'd0, out_re_axis_tdata}, {16'd0, held_re});
        chk("hold_im", {16'd0, out_im_axis_tdata}, {16'd0, held_im});
        chk("hold_last", {31'd0, out_axis_tlast}, {31'd0, held_last});
      end
      if (out_axis_tvalid && out_axis_tready)
        q.push_back('{re: out_re_axis_tdata, im: out_im_axis_tdata, last: out_axis_tlast});
      stalled_prev = out_axis_tvalid && !out_axis_tready;
      held_re   = out_re_axis_tdata;
      held_im   = out_im_axis_tdata;
      held_last = out_axis_tlast;
    end
  end

  // Start pulse with a junk sample offered in the same cycle; it must be discarded.
  task automatic start(input logic [7:0] n);
    start_in = 1'b1;
    num_symbols_in = n;
    in_axis_tvalid = 1'b1;
    in_re_axis_tdata = 16'h7fff;
    in_im_axis_tdata = 16'h7fff;
    out_axis_tready = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    in_axis_tvalid = 1'b0;
    k = 0;
  endtask

  task automatic drive(input int n, input bit gaps, input bit rnd_rdy,
                       input int restart_at, input int stop_beats);
    int  got = 0;
    int  cyc = 0;
    bit  acc;
    bit  stopped = 0;
    while (got < n && cyc < 5000) begin
      if (stop_beats > 0 && q.size() >= stop_beats) begin
        stopped = 1;
        break;
      end
      in_axis_tvalid   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_re_axis_tdata = 16'(k);
      in_im_axis_tdata = 16'(-k);
      out_axis_tready  = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      start_in         = (got == restart_at);
      if (got == restart_at) num_symbols_in = 8'd5;
      @(negedge clk_in);
      acc = in_axis_tvalid && in_axis_tready;
      @(posedge clk_in); #1;
      if (acc) begin
        got++;
        k++;
      end
      cyc++;
    end
    in_axis_tvalid = 1'b0;
    start_in = 1'b0;
    if (!stopped) chk("drive_done", 32'(got), 32'(n));
  endtask

  task automatic drain();
    out_axis_tready = 1'b1;
    in_axis_tvalid = 1'b0;
    repeat (4) @(posedge clk_in);
    #1;
    chk("drained_tvalid", {31'd0, out_axis_tvalid}, 32'd0);
  endtask

  task automatic check_blocks(input int nblk);
    int e;
    chk("beat_count", 32'(q.size()), 32'(64 * nblk));
    for (int i = 0; i < q.size() && i < 64 * nblk; i++) begin
      e = (i / 64) * 80 + 16 + (i % 64);
      chk($sformatf("re[%0d]", i), {16'd0, q[i].re}, {16'd0, 16'(e)});
      chk($sformatf("im[%0d]", i), {16'd0, q[i].im}, {16'd0, 16'(-e)});
      chk($sformatf("last[%0d]", i), {31'd0, q[i].last}, {31'd0, (i % 64) == 63});
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_tvalid", {31'd0, out_axis_tvalid}, 32'd0);
    chk("rst_tlast", {31'd0, out_axis_tlast}, 32'd0);
    chk("rst_re", {16'd0, out_re_axis_tdata}, 32'd0);
    chk("rst_im", {16'd0, out_im_axis_tdata}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tready", {31'd0, in_axis_tready}, 32'd0);
    rst_in = 1'b0;
    #1;
    chk("idle_tready", {31'd0, in_axis_tready}, 32'd1);

    // Continuous ramp, two symbols, downstream always ready
    q.delete();
    start(8'd2);
    chk("t1_busy_after_start", {31'd0, busy}, 32'd1);
    drive(159, 0, 0, -1, 0);
    chk("t1_busy_before_last", {31'd0, busy}, 32'd1);
    drive(1, 0, 0, -1, 0);
    chk("t1_busy_after_last", {31'd0, busy}, 32'd0);
    drain();
    drive(40, 0, 0, -1, 0);
    drain();
    check_blocks(2);
    $display("step continuous_ramp beats=%0d", q.size());

    // Random downstream backpressure
    q.delete();
    start(8'd2);
    drive(160, 0, 1, -1, 0);
    drain();
    chk("t2_busy", {31'd0, busy}, 32'd0);
    check_blocks(2);
    $display("step random_ready beats=%0d", q.size());

    // Input gaps together with backpressure
    q.delete();
    start(8'd2);
    drive(160, 1, 1, -1, 0);
    drain();
    chk("t3_busy", {31'd0, busy}, 32'd0);
    check_blocks(2);
    $display("step input_gaps beats=%0d", q.size());

    // Zero symbols: start ignored
    q.delete();
    start(8'd0);
    chk("t4_busy_after_start", {31'd0, busy}, 32'd0);
    drive(100, 0, 0, -1, 0);
    drain();
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_beats", 32'(q.size()), 32'd0);
    $display("step zero_symbols beats=%0d", q.size());

    // Second start during symbol 0 is ignored
    q.delete();
    start(8'd2);
    drive(160, 0, 0, 40, 0);
    drain();
    chk("t5_busy", {31'd0, busy}, 32'd0);
    check_blocks(2);
    $display("step restart_ignored beats=%0d", q.size());

    // Reset at output beat 30, then a fresh one-symbol start
    q.delete();
    start(8'd2);
    drive(200, 0, 0, -1, 30);
    rst_in = 1'b1;
    in_axis_tvalid = 1'b0;
    #1;
    chk("t6_tready_in_rst", {31'd0, in_axis_tready}, 32'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    chk("t6_tvalid_after_rst", {31'd0, out_axis_tvalid}, 32'd0);
    chk("t6_busy_after_rst", {31'd0, busy}, 32'd0);
    q.delete();
    drive(40, 0, 0, -1, 0);
    drain();
    chk("t6_idle_beats", 32'(q.size()), 32'd0);
    start(8'd1);
    drive(80, 0, 0, -1, 0);
    drain();
    check_blocks(1);
    $display("step reset_mid_emit beats=%0d", q.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
